pc_fetch: RTL
=============

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The module SHALL have one clock and one reset: the clock SHALL be `clk`, and the reset SHALL be `rst_n`, asynchronous and active-low.
REQ-002 The module SHALL provide parameter RESET_PC, default 32'h0040_0000: the PC value loaded on reset.
REQ-003 The ports SHALL be as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- next_pc  in  32  selected next PC, driven by the 2:1 next-PC mux output.
- redirect  in  1  branch or jump redirect request.
- redirect_pc  in  32  redirect target.
- stall  in  1  hazard stall; blocks PC advance.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  memory response valid; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched word.
- instr_valid  out  1  instr holds a valid instruction.
- instr_ready  in  1  decode stage accepts instr.
- instr  out  32  fetched instruction.
- pc_out  out  32  address of the current fetch or held instruction.
- pc_plus4  out  32  pc_out+4, feeding mux data input D0.
- align_err  out  1  one-cycle pulse: a misaligned PC was loaded.

Function
REQ-004 FSM states SHALL be IDLE, FETCH and HOLD, with a state register and registered outputs except where stated.
REQ-005 IDLE: imem_req=0; the FSM SHALL go unconditionally to FETCH on the next cycle.
REQ-006 FETCH: imem_req=1 and imem_addr=pc_out, both held stable until imem_ack.
- On imem_ack without redirect: instr<=imem_rdata, instr_valid<=1, go to HOLD.
- Latency SHALL be one cycle from ack to instr_valid.
REQ-007 HOLD: imem_req=0 and instr held stable.
- On instr_ready=1 and stall=0 and redirect=0: pc<=next_pc, instr_valid<=0, go to FETCH.
- instr_ready=1 with stall=1 SHALL NOT advance.
REQ-008 redirect=1 in any state SHALL take priority over everything else: pc<=redirect_pc, instr_valid<=0, go to IDLE; a same-cycle imem_ack SHALL be discarded.
REQ-009 stall SHALL have no effect in IDLE or FETCH.
REQ-010 Every PC load SHALL clear bits [1:0]; if the source bits [1:0]!=0, align_err SHALL be 1 for exactly the next cycle, otherwise 0.
REQ-011 pc_plus4 SHALL be combinational pc_out+32'd4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-012 Back-to-back throughput SHALL be one instruction per 2 cycles minimum with zero-wait memory: FETCH with ack, then HOLD with ready.
REQ-013 imem_ack in IDLE or HOLD SHALL be ignored.

Reset
REQ-014 While rst_n=0, asynchronously: state=IDLE, pc_out=RESET_PC, instr=32'h0000_0000 (NOP), instr_valid=0, align_err=0, imem_req=0.
REQ-015 Reset deassertion mid-fetch SHALL abandon the outstanding request; the first request after reset SHALL come one cycle after the first rising edge with rst_n=1 (IDLE->FETCH).
REQ-016 No output SHALL be X after reset.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset, zero-wait memory, instr_ready=1, next_pc=pc_plus4: imem_addr sequence 0x00400000, 0x00400004, 0x00400008; each instr equals the memory word.
- imem_ack delayed 3 cycles: imem_req and imem_addr stay stable for 3 cycles; instr_valid rises the cycle after ack.
- HOLD with stall=1 for 4 cycles and instr_ready=1: pc_out and instr unchanged; pc advances the cycle after stall drops.
- redirect=1 with redirect_pc=0x00400100 in the same cycle as imem_ack: data dropped, instr_valid=0, IDLE, then fetch at 0x00400100.
- next_pc=0x00400006: pc_out=0x00400004 and align_err pulses for one cycle; next_pc=0xFFFFFFFC gives pc_plus4=0x00000000.
- rst_n pulsed low during FETCH: outputs go to reset values immediately; refetch from RESET_PC.

Source files
------------

// File: rtl/pc_fetch.sv
// Fetch-stage PC register and instruction-memory handshake (IDLE/FETCH/HOLD); instr_valid one cycle after imem_ack.
// Backpressure: HOLD keeps instr until decode is ready and no stall; redirect overrides everything.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        align_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;

  assign pc_out    = pc;
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0000_0000;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      align_err <= 1'b0;
      // Redirect wins over any pending ack, ready or stall in every state.
      if (redirect) begin
        pc          <= {redirect_pc[31:2], 2'b00};
        align_err   <= |redirect_pc[1:0];
        instr_valid <= 1'b0;
        imem_req    <= 1'b0;
        state       <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            imem_req <= 1'b1;
            state    <= FETCH;
          end
          FETCH: begin
            if (imem_ack) begin
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
              imem_req    <= 1'b0;
              state       <= HOLD;
            end
          end
          HOLD: begin
            if (instr_ready && !stall) begin
              pc          <= {next_pc[31:2], 2'b00};
              align_err   <= |next_pc[1:0];
              instr_valid <= 1'b0;
              imem_req    <= 1'b1;
              state       <= FETCH;
            end
          end
          default: begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
